// File: rtl/pipe_wb_regfile.sv
// Write-back select and 32x32 register file with a sequential post-reset scrub.
// Optional WB-to-ID write-through forwarding is compiled in with RF_WB_BYPASS_EN.
module pipe_wb_regfile #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          wwreg,
    input  logic          wm2reg,
    input  logic [DW-1:0] wmo,
    input  logic [DW-1:0] walu,
    input  logic [4:0]    wrn,
    input  logic [4:0]    rna,
    input  logic [4:0]    rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic [DW-1:0] wdi,
    output logic          busy
);

    typedef enum logic {StIdle, StScrub} state_e;

    state_e        r_state;
    logic [4:0]    r_sidx;
    logic          r_busy;
    logic [DW-1:0] r_regs [NREG];

    logic          w_we;
    logic [4:0]    w_waddr;
    logic [DW-1:0] w_wdata;

    assign wdi  = wm2reg ? wmo : walu;
    assign busy = r_busy;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= StScrub;
            r_sidx  <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                StScrub: begin
                    r_sidx <= r_sidx + 5'd1;
                    if (r_sidx == 5'(NREG - 1)) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scrub and commit share one write port; the scrub owns it while busy.
    assign w_we    = !clr && (r_busy || (wwreg && (wrn != 5'd0)));
    assign w_waddr = r_busy ? r_sidx : wrn;
    assign w_wdata = r_busy ? '0 : wdi;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic w_fwd;
    assign w_fwd = wwreg && (wrn != 5'd0);
`endif

    always_comb begin
        qa = '0;
        qb = '0;
        if (!r_busy) begin
            if (rna != 5'd0) begin
                qa = r_regs[rna];
            end
            if (rnb != 5'd0) begin
                qb = r_regs[rnb];
            end
`ifdef RF_WB_BYPASS_EN
            if (w_fwd && (rna == wrn)) begin
                qa = wdi;
            end
            if (w_fwd && (rnb == wrn)) begin
                qb = wdi;
            end
`endif
        end
    end

endmodule

// File: doc/pipe_wb_regfile.md
# pipe_wb_regfile

Write-back stage and general-purpose register file of the five-stage pipelined CPU. It consumes the MEM/WB pipeline register outputs, selects the write-back data (memory load data or ALU result), and commits it to the 32x32 register file. It serves the two ID-stage read ports with same-cycle write-through forwarding. After reset it runs a sequential scrub that clears the register array one entry per cycle, so the array maps onto single-write-port storage, and reports `busy` to the hazard unit while the scrub runs.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers; the index width is 5 bits.
- `DW`, 32: data width.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `clr` input 1: synchronous, active-high reset.
- `wwreg` input 1: register write enable from the MEM/WB register.
- `wm2reg` input 1: 1 selects `wmo`, 0 selects `walu`.
- `wmo` input 32: data-memory load value.
- `walu` input 32: ALU result.
- `wrn` input 5: destination register number.
- `rna` input 5: read port A address.
- `rnb` input 5: read port B address.
- `qa` output 32: read port A data.
- `qb` output 32: read port B data.
- `wdi` output 32: selected write-back data, combinational.
- `busy` output 1: scrub in progress; the hazard unit stalls IF/ID while `busy` is high.

## Operation
- `wdi = wm2reg ? wmo : walu`. This output is always valid and does not depend on `busy`.
- Commit: on a rising edge with `wwreg=1`, `wrn!=0`, `busy=0` and `clr=0`, `reg[wrn] <= wdi`.
- Register 0 reads as 0 at all times, and writes to register 0 are discarded.
- Scrub state machine, states IDLE and SCRUB, with a 5-bit index `sidx`:
  - Any edge with `clr=1`: state becomes SCRUB, `sidx <= 0`, `busy <= 1`. Array contents are not modified on that edge.
  - SCRUB with `clr=0`: `reg[sidx] <= 0` and `sidx <= sidx+1`. When `sidx==31`, state becomes IDLE and `busy <= 0`.
  - IDLE: holds until `clr` is asserted.
- Writes arriving while `busy=1` are dropped. The pipeline is stalled during the scrub, so no real write is lost.
- Reads:
  - `busy=1`: `qa = qb = 0`.
  - Otherwise: `qa = (rna==0) ? 0 : reg[rna]`, subject to bypass (see Configuration). `qb` is the same with `rnb`.
- If `clr` is reasserted mid-scrub, `sidx` restarts at 0 and the scrub runs a full 32 entries again.

## Timing
- Reset values: `busy=1` from the first edge with `clr` sampled high. `qa=qb=0` while `busy=1`. The state is SCRUB.
- Scrub latency: after `clr` falls, exactly 32 rising edges until `busy=0`. `busy` is low in the cycle following the 32nd edge.
- Write latency: a write is visible in the array one edge after commit. With bypass it is visible combinationally in the same cycle.
- `qa`, `qb` and `wdi` are combinational from their inputs and from the array state. There is no output register.
- Simultaneous `wwreg=1` and `clr=1`: reset wins and the write is discarded.
- Both read ports addressing `wrn` in the same cycle: both receive the bypassed value (when bypass is compiled in).

## Configuration
- `RF_WB_BYPASS_EN` defined:
  - When `busy=0`, `wwreg=1`, `wrn!=0` and `rna==wrn`, `qa = wdi`. `qb` behaves the same with `rnb`.
  - This resolves the WB-to-ID hazard with no stall.
- `RF_WB_BYPASS_EN` undefined:
  - `qa` and `qb` always return the stored array value, which is the pre-write value in the commit cycle.
  - The hazard unit must insert one extra stall for a WB-to-ID dependency.

## Test plan
- Scrub: preload the array with nonzero values, pulse `clr` for 1 cycle -> `busy` stays high for 32 edges, then falls; reading all 32 registers returns 0.
- Write-back select: `wwreg=1`, `wrn=5`, `wm2reg=1`, `wmo=0xDEADBEEF`, `walu=0x12345678`; next cycle read `rna=5` -> `qa=0xDEADBEEF`. Repeat with `wm2reg=0` -> `qa=0x12345678`.
- Register 0: write `0xFFFFFFFF` to `wrn=0` -> `qa` at `rna=0` stays 0 in the same cycle and in the next cycle, with or without the macro.
- Bypass: `wwreg=1`, `wrn=7`, `walu=0xA5A5A5A5`, `rna=rnb=7` in the same cycle -> `qa=qb=0xA5A5A5A5` with `RF_WB_BYPASS_EN`; both equal the old `reg[7]` without it.
- Reset collisions: assert `clr` with `wwreg=1` -> the write is dropped. Reassert `clr` at `sidx=20` -> `busy` stays high for a further 32 edges after release, and all registers read 0.
- Writes during scrub: drive `wwreg=1`, `wrn=3`, `walu=0x55` while `busy=1` -> `reg[3]` reads 0 after the scrub completes.
